// File: rtl/skip_table_write_ctrl_pkg.sv
//============================================================================
// Module : skip_table_write_ctrl_pkg
// Brief  : Shared types and constants for the skip-table write sequencer.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

package skip_table_write_ctrl_pkg;

  localparam int          SKIP_TABLE_SIZE   = 8;
  localparam logic [31:0] SkipTableBlockIdx = 32'h0000_05A3;

  localparam logic [1:0]  SKIP_OFF_PC       = 2'd0;
  localparam logic [1:0]  SKIP_OFF_VALID    = 2'd1;
  localparam logic [31:0] SKIP_VALID_DATA   = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INVAL  = 2'd1,
    WR_PC  = 2'd2,
    WR_VLD = 2'd3
  } SkipWrStateType;

  // idx is carried zero-extended so the struct is independent of table size
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] pc;
    logic        setValid;
  } SkipWrReqType;

  function automatic logic [31:0] skip_wr_addr(input logic [31:0] idx,
                                               input logic [1:0]  off,
                                               input int          idx_w);
    return (SkipTableBlockIdx << (idx_w + 2)) | (idx << 2) | {30'b0, off};
  endfunction

endpackage

`default_nettype wire

// File: rtl/skip_table_write_ctrl_rr_arbiter.sv
//============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; grants first request at or
//          after the pointer, wrapping modulo NUM_REQ.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  always_comb begin
    logic found;
    int   k;
    grant_o = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[k]) begin
        grant_o[k] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/skip_table_write_ctrl.sv
//============================================================================
// Module : skip_table_write_ctrl
// Brief  : Arbitrates requesters and sequences skip-table installs as
//          invalidate -> PC write -> valid write. Optional macro
//          SKIP_WRITE_SHADOW_EN adds a per-entry valid mirror output.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module skip_table_write_ctrl
  import skip_table_write_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int TABLE_SIZE = SKIP_TABLE_SIZE
) (
  input  logic                        ClockIn,
  input  logic                        ResetIn,
  input  logic [NUM_REQ-1:0]          ReqValidIn,
  input  logic [NUM_REQ*$clog2(TABLE_SIZE)-1:0] ReqIdxIn,
  input  logic [NUM_REQ*32-1:0]       ReqPCIn,
  input  logic [NUM_REQ-1:0]          ReqSetValidIn,
  output logic [NUM_REQ-1:0]          ReqReadyOut,
  output logic [NUM_REQ-1:0]          ReqDoneOut,
  output logic                        BusyOut,
  output logic                        WriteEnOut,
  output logic [31:0]                 WriteAddressOut,
  output logic [31:0]                 WriteDataOut
`ifdef SKIP_WRITE_SHADOW_EN
  ,
  output logic [TABLE_SIZE-1:0]       ShadowValidOut
`endif
);

  localparam int IDX_W = $clog2(TABLE_SIZE);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  SkipWrStateType   state_q, state_d;
  SkipWrReqType     req_q, req_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [PTR_W-1:0] gnt_enc;
  logic [NUM_REQ-1:0] grant;
  logic             wr_en;
  logic [1:0]       wr_off;
  logic [31:0]      wr_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i   (ReqValidIn),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    gnt_enc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_enc = PTR_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    ReqReadyOut = '0;
    ReqDoneOut  = '0;
    wr_en       = 1'b0;
    wr_off      = SKIP_OFF_PC;
    wr_data     = '0;
    case (state_q)
      IDLE: begin
        // Ready is held low while reset is asserted so no grant is lost
        if ((|ReqValidIn) && !ResetIn) begin
          ReqReadyOut    = grant;
          gnt_idx_d      = gnt_enc;
          req_d.idx      = 32'(ReqIdxIn[int'(gnt_enc)*IDX_W +: IDX_W]);
          req_d.pc       = ReqPCIn[int'(gnt_enc)*32 +: 32];
          req_d.setValid = ReqSetValidIn[gnt_enc];
          ptr_d          = (gnt_enc == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_enc + PTR_W'(1);
          state_d        = INVAL;
        end
      end
      INVAL: begin
        wr_en  = 1'b1;
        wr_off = SKIP_OFF_VALID;
        if (!req_q.setValid) begin
          ReqDoneOut = NUM_REQ'(1) << gnt_idx_q;
          state_d    = IDLE;
        end else begin
          state_d = WR_PC;
        end
      end
      WR_PC: begin
        wr_en   = 1'b1;
        wr_off  = SKIP_OFF_PC;
        wr_data = req_q.pc;
        state_d = WR_VLD;
      end
      WR_VLD: begin
        wr_en      = 1'b1;
        wr_off     = SKIP_OFF_VALID;
        wr_data    = SKIP_VALID_DATA;
        ReqDoneOut = NUM_REQ'(1) << gnt_idx_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign BusyOut         = (state_q != IDLE);
  assign WriteEnOut      = wr_en;
  assign WriteDataOut    = wr_data;
  assign WriteAddressOut = wr_en ? skip_wr_addr(req_q.idx, wr_off, IDX_W) : '0;

  always_ff @(posedge ClockIn) begin
    if (ResetIn) begin
      state_q   <= IDLE;
      req_q     <= '0;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

`ifdef SKIP_WRITE_SHADOW_EN
  logic [TABLE_SIZE-1:0] shadow_q;

  always_ff @(posedge ClockIn) begin
    if (ResetIn) begin
      shadow_q <= '0;
    end else if (state_q == INVAL) begin
      shadow_q[req_q.idx[IDX_W-1:0]] <= 1'b0;
    end else if (state_q == WR_VLD) begin
      shadow_q[req_q.idx[IDX_W-1:0]] <= 1'b1;
    end
  end

  assign ShadowValidOut = shadow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_skip_table_write_ctrl.sv
//============================================================================
// Module : tb_skip_table_write_ctrl
// Brief  : Self-checking bench for skip_table_write_ctrl against a
//          transaction-level reference model.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_skip_table_write_ctrl;
  import skip_table_write_ctrl_pkg::*;

  localparam int NUM_REQ    = 2;
  localparam int TABLE_SIZE = 8;
  localparam int IDX_W      = 3;
  localparam logic [31:0] B = SkipTableBlockIdx << (IDX_W + 2);

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*IDX_W-1:0]  req_idx;
  logic [NUM_REQ*32-1:0]     req_pc;
  logic [NUM_REQ-1:0]        req_set;
  logic [NUM_REQ-1:0]        ready, done;
  logic                      busy, we;
  logic [31:0]               addr, data;
`ifdef SKIP_WRITE_SHADOW_EN
  logic [TABLE_SIZE-1:0]     shadow;
`endif

  always #5 clk = ~clk;

  skip_table_write_ctrl #(.NUM_REQ(NUM_REQ), .TABLE_SIZE(TABLE_SIZE)) dut (
    .ClockIn         (clk),
    .ResetIn         (rst),
    .ReqValidIn      (req_valid),
    .ReqIdxIn        (req_idx),
    .ReqPCIn         (req_pc),
    .ReqSetValidIn   (req_set),
    .ReqReadyOut     (ready),
    .ReqDoneOut      (done),
    .BusyOut         (busy),
    .WriteEnOut      (we),
    .WriteAddressOut (addr),
    .WriteDataOut    (data)
`ifdef SKIP_WRITE_SHADOW_EN
    ,
    .ShadowValidOut  (shadow)
`endif
  );

  // One expected write beat per busy cycle; sh: -1 none, 0 clear, 1 set
  typedef struct {
    logic [31:0]        addr;
    logic [31:0]        data;
    logic [NUM_REQ-1:0] done;
    int                 sh;
    int                 shi;
  } beat_t;

  beat_t                 beats[$];
  int                    ptr_m;
  logic [TABLE_SIZE-1:0] sh_m;
  logic [NUM_REQ-1:0]    granted;
  int                    n_checks = 0;
  int                    n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int idx, input int off);
    return B | 32'(idx << 2) | 32'(off);
  endfunction

  task automatic set_req(input int i, input logic v, input int idx, input logic [31:0] pc, input logic s);
    req_valid[i]               = v;
    req_idx[i*IDX_W +: IDX_W]  = IDX_W'(idx);
    req_pc[i*32 +: 32]         = pc;
    req_set[i]                 = s;
  endtask

  // Check one cycle at the falling edge, advance the model, then step past the rising edge
  task automatic cycle();
    beat_t b;
    int    g;
    int    idx;
    @(negedge clk);
    granted = '0;
`ifdef SKIP_WRITE_SHADOW_EN
    check_val("shadow", 32'(shadow), 32'(sh_m));
`endif
    check_val("ready_onehot", 32'($countones(ready) <= 1), 32'd1);
    if (beats.size() == 0) begin
      g = -1;
      if (!rst) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          int k;
          k = (ptr_m + i) % NUM_REQ;
          if (g < 0 && req_valid[k]) g = k;
        end
      end
      check_val("ready", 32'(ready), (g < 0) ? 32'd0 : 32'(1 << g));
      check_val("idle_we", 32'(we), 32'd0);
      check_val("idle_addr", addr, 32'd0);
      check_val("idle_data", data, 32'd0);
      check_val("idle_done", 32'(done), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);
      if (g >= 0) begin
        granted[g] = 1'b1;
        ptr_m      = (g + 1) % NUM_REQ;
        idx        = int'(req_idx[g*IDX_W +: IDX_W]);
        beats.push_back('{exp_addr(idx, 1), 32'd0,
                          req_set[g] ? NUM_REQ'(0) : NUM_REQ'(1 << g), 0, idx});
        if (req_set[g]) begin
          beats.push_back('{exp_addr(idx, 0), req_pc[g*32 +: 32], NUM_REQ'(0), -1, idx});
          beats.push_back('{exp_addr(idx, 1), 32'h8000_0000, NUM_REQ'(1 << g), 1, idx});
        end
      end
    end else begin
      b = beats.pop_front();
      check_val("busy_ready", 32'(ready), 32'd0);
      check_val("we", 32'(we), 32'd1);
      check_val("addr", addr, b.addr);
      check_val("data", data, b.data);
      check_val("done", 32'(done), 32'(b.done));
      check_val("busy", 32'(busy), 32'd1);
      if (b.sh == 0) sh_m[b.shi] = 1'b0;
      else if (b.sh == 1) sh_m[b.shi] = 1'b1;
    end
    if (rst) begin
      beats.delete();
      ptr_m = 0;
      sh_m  = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drop_granted();
    req_valid = req_valid & ~granted;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_idx   = '0;
    req_pc    = '0;
    req_set   = '0;
    ptr_m     = 0;
    sh_m      = '0;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // Install idx 3 from requester 0
    set_req(0, 1'b1, 3, 32'h0000_1040, 1'b1);
    cycle();
    drop_granted();
    repeat (4) cycle();

    // Invalidate-only idx 7 from requester 1
    set_req(1, 1'b1, 7, 32'hDEAD_BEEF, 1'b0);
    cycle();
    drop_granted();
    repeat (2) cycle();

    // Both requesters held valid: alternate grants
    set_req(0, 1'b1, 1, 32'h0000_2000, 1'b1);
    set_req(1, 1'b1, 2, 32'h0000_3000, 1'b1);
    repeat (16) cycle();
    req_valid = '0;
    repeat (4) cycle();

    // Only requester 1, twice: pointer wraps, no stall between
    set_req(1, 1'b1, 5, 32'h0000_4000, 1'b0);
    cycle();
    drop_granted();
    cycle();
    set_req(1, 1'b1, 6, 32'h0000_5000, 1'b0);
    cycle();
    drop_granted();
    repeat (3) cycle();

    // Reset during WR_PC
    set_req(0, 1'b1, 2, 32'h0000_6000, 1'b1);
    cycle();
    drop_granted();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // Install then invalidate the same entry
    set_req(0, 1'b1, 3, 32'h0000_7000, 1'b1);
    cycle();
    drop_granted();
    repeat (4) cycle();
    set_req(0, 1'b1, 3, 32'h0000_0000, 1'b0);
    cycle();
    drop_granted();
    repeat (3) cycle();

    // Randomized traffic including dropped requests and occasional resets
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (granted[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(i, 1'b1, int'($urandom_range(0, TABLE_SIZE - 1)), $urandom, 1'($urandom_range(0, 1)));
          else
            req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      cycle();
    end
    rst       = 1'b0;
    req_valid = '0;
    repeat (5) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
